// File: rtl/nios_tester_pkg.sv
// nios_tester_pkg: shared edge-mode encodings and edge selection for tester inputs
package nios_tester_pkg;
  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_BOTH = 2;
  function automatic logic edge_hit(int mode, logic level_new);
    return mode == EDGE_BOTH || (mode == EDGE_RISE && level_new) || (mode == EDGE_FALL && !level_new);
  endfunction
endpackage

// File: rtl/nios_tester_sync2.sv
// nios_tester_sync2: two-flop synchroniser with selectable reset value
module nios_tester_sync2 #(
  parameter bit RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);
  logic s1;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) {q, s1} <= {2{RESET_VAL}};
    else {q, s1} <= {s1, d};
endmodule

// File: rtl/nios_tester_input_cond.sv
// nios_tester_input_cond: synchronise, debounce and edge-capture a raw input for the PIO in_port
module nios_tester_input_cond
  import nios_tester_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int EDGE_MODE       = EDGE_FALL,
  parameter bit RESET_LEVEL     = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic in_raw,
  input  logic clear,
  output logic level_out,
  output logic rise_pulse,
  output logic fall_pulse,
  output logic capture_out
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic s2;
  logic [CW-1:0] cnt;
  logic accept;
  nios_tester_sync2 #(.RESET_VAL(RESET_LEVEL)) u_sync (
    .clk(clk), .reset_n(reset_n), .d(in_raw), .q(s2)
  );
  // a new level is taken on the DEBOUNCE_CYCLES-th consecutive differing sample
  assign accept = s2 != level_out && cnt == CW'(DEBOUNCE_CYCLES - 1);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      cnt         <= '0;
      level_out   <= RESET_LEVEL;
      rise_pulse  <= 1'b0;
      fall_pulse  <= 1'b0;
      capture_out <= 1'b0;
    end else begin
      cnt         <= (s2 == level_out || accept) ? '0 : cnt + 1'b1;
      level_out   <= accept ? s2 : level_out;
      rise_pulse  <= accept && s2;
      fall_pulse  <= accept && !s2;
      capture_out <= (accept && edge_hit(EDGE_MODE, s2)) ? 1'b1 : clear ? 1'b0 : capture_out;
    end
endmodule

// File: tb/tb_nios_tester_input_cond.sv
// tb_nios_tester_input_cond: directed and random checks of three conditioner variants against a window model
module tb_nios_tester_input_cond;
  logic clk = 1'b0, reset_n, in_raw, clear;
  logic [2:0] lvl_d, rise_d, fall_d, cap_d;
  int nvec = 0, nerr = 0;
  localparam int DC [3] = '{4, 4, 1};
  localparam int EM [3] = '{2, 0, 1};
  localparam bit RL [3] = '{1'b1, 1'b1, 1'b0};
  always #5 clk = ~clk;

  nios_tester_input_cond #(.DEBOUNCE_CYCLES(4), .EDGE_MODE(2), .RESET_LEVEL(1'b1)) dut0 (
    .clk(clk), .reset_n(reset_n), .in_raw(in_raw), .clear(clear),
    .level_out(lvl_d[0]), .rise_pulse(rise_d[0]), .fall_pulse(fall_d[0]), .capture_out(cap_d[0]));
  nios_tester_input_cond #(.DEBOUNCE_CYCLES(4), .EDGE_MODE(0), .RESET_LEVEL(1'b1)) dut1 (
    .clk(clk), .reset_n(reset_n), .in_raw(in_raw), .clear(clear),
    .level_out(lvl_d[1]), .rise_pulse(rise_d[1]), .fall_pulse(fall_d[1]), .capture_out(cap_d[1]));
  nios_tester_input_cond #(.DEBOUNCE_CYCLES(1), .EDGE_MODE(1), .RESET_LEVEL(1'b0)) dut2 (
    .clk(clk), .reset_n(reset_n), .in_raw(in_raw), .clear(clear),
    .level_out(lvl_d[2]), .rise_pulse(rise_d[2]), .fall_pulse(fall_d[2]), .capture_out(cap_d[2]));

  // model: h[i][k] is the raw pin sampled k+1 edges ago; the level flips once the
  // synchronised view (two edges late) has disagreed with it for DC samples in a row
  logic h [3][8];
  logic lvl_m [3], rise_m [3], fall_m [3], cap_m [3];
  always @(posedge clk or negedge reset_n)
    for (int i = 0; i < 3; i++) begin
      if (!reset_n) begin
        for (int k = 0; k < 8; k++) h[i][k] <= RL[i];
        lvl_m[i] <= RL[i];
        rise_m[i] <= 1'b0;
        fall_m[i] <= 1'b0;
        cap_m[i] <= 1'b0;
      end else begin
        automatic logic fl = 1'b1;
        automatic logic nl;
        automatic logic hit;
        for (int k = 1; k <= DC[i]; k++) if (h[i][k] == lvl_m[i]) fl = 1'b0;
        nl = fl ? ~lvl_m[i] : lvl_m[i];
        hit = fl && (EM[i] == 2 || (EM[i] == 0 && nl) || (EM[i] == 1 && !nl));
        lvl_m[i] <= nl;
        rise_m[i] <= fl && nl;
        fall_m[i] <= fl && !nl;
        cap_m[i] <= hit ? 1'b1 : clear ? 1'b0 : cap_m[i];
        for (int k = 7; k > 0; k--) h[i][k] <= h[i][k-1];
        h[i][0] <= in_raw;
      end
    end

  task automatic chk(input string nm, input int act, input int exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk)
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("level%0d", i), int'(lvl_d[i]), int'(lvl_m[i]));
      chk($sformatf("rise%0d", i), int'(rise_d[i]), int'(rise_m[i]));
      chk($sformatf("fall%0d", i), int'(fall_d[i]), int'(fall_m[i]));
      chk($sformatf("capture%0d", i), int'(cap_d[i]), int'(cap_m[i]));
    end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_lvl(input logic v, output int n);
    n = -1;
    for (int i = 1; i <= 30; i++) begin
      step(1);
      if (lvl_d[0] === v) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    int n, hold;
    reset_n = 1'b0; in_raw = 1'b1; clear = 1'b0;
    step(3);
    reset_n = 1'b1;
    step(20);
    chk("idle_level", int'(lvl_d[0]), 1);
    chk("idle_capture", int'(cap_d[0]), 0);
    in_raw = 1'b0; step(3); in_raw = 1'b1; step(10);
    chk("glitch_level", int'(lvl_d[0]), 1);
    chk("glitch_capture", int'(cap_d[0]), 0);
    in_raw = 1'b0;
    wait_lvl(1'b0, n);
    chk("fall_latency", n, 6);
    chk("fall_pulse", int'(fall_d[0]), 1);
    chk("fall_capture", int'(cap_d[0]), 1);
    chk("risemode_fall_capture", int'(cap_d[1]), 0);
    step(1);
    chk("fall_pulse_width", int'(fall_d[0]), 0);
    clear = 1'b1; step(1); clear = 1'b0;
    chk("clear_capture", int'(cap_d[0]), 0);
    in_raw = 1'b1; step(5);
    clear = 1'b1; step(1); clear = 1'b0;
    chk("rise_level", int'(lvl_d[0]), 1);
    chk("rise_pulse", int'(rise_d[0]), 1);
    chk("clear_vs_set", int'(cap_d[0]), 1);
    chk("risemode_capture", int'(cap_d[1]), 1);
    clear = 1'b1; step(1); clear = 1'b0;
    in_raw = 1'b0; step(2); in_raw = 1'b1; step(2);
    in_raw = 1'b0; step(2); in_raw = 1'b1; step(2);
    in_raw = 1'b0;
    wait_lvl(1'b0, n);
    chk("bounce_latency", n, 6);
    chk("bounce_fall_pulse", int'(fall_d[0]), 1);
    chk("risemode_bounce_capture", int'(cap_d[1]), 0);
    in_raw = 1'b1;
    wait_lvl(1'b1, n);
    chk("rerise_latency", n, 6);
    in_raw = 1'b0; step(3);
    reset_n = 1'b0; #1;
    chk("rst_level", int'(lvl_d[0]), 1);
    chk("rst_capture", int'(cap_d[0]), 0);
    chk("rst_pulses", int'({rise_d[0], fall_d[0]}), 0);
    step(1);
    reset_n = 1'b1;
    wait_lvl(1'b0, n);
    chk("post_reset_latency", n, 6);
    chk("post_reset_fall", int'(fall_d[0]), 1);
    hold = 0;
    for (int c = 0; c < 4000; c++) begin
      if (hold == 0) begin
        in_raw = 1'($urandom);
        hold = $urandom_range(1, 9);
      end
      hold--;
      clear = ($urandom % 10) == 0;
      reset_n = ($urandom % 400) != 0;
      step(1);
    end
    reset_n = 1'b1; clear = 1'b0;
    step(2);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/nios_tester_input_cond.md
NIOS_TESTER_INPUT_COND -- requirements
Module: nios_tester_input_cond

Upstream conditioner for the 1-bit input PIO: synchronises, debounces and edge-captures a raw board input; capture_out drives the PIO in_port.

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000, consecutive differing synchronised samples required to accept a new level (legal range >= 1).
REQ-002 Parameter EDGE_MODE, default 1, edge that sets capture: 0 = rising, 1 = falling, 2 = both.
REQ-003 Parameter RESET_LEVEL, default 1, assumed idle level of the pulled-up input.
REQ-004 clk  input  1  system clock; all logic on rising edge.
REQ-005 reset_n  input  1  reset, asynchronous, active-low.
REQ-006 in_raw  input  1  asynchronous raw pin.
REQ-007 clear  input  1  synchronous single-cycle request to clear capture_out.
REQ-008 level_out  output  1  debounced stable level.
REQ-009 rise_pulse  output  1  one-cycle strobe on accepted 0->1.
REQ-010 fall_pulse  output  1  one-cycle strobe on accepted 1->0.
REQ-011 capture_out  output  1  sticky edge flag; feeds PIO in_port.

Function
REQ-012 in_raw SHALL pass through a two-flop synchroniser; its output is s2.
REQ-013 Debounce counter width SHALL be clog2(DEBOUNCE_CYCLES+1); the counter never wraps.
REQ-014 Any cycle with s2 == level_out SHALL reset the counter to 0.
REQ-015 Each cycle with s2 != level_out SHALL increment the counter; on the cycle where the counter equals DEBOUNCE_CYCLES-1, level_out SHALL load s2 and the counter SHALL return to 0.
REQ-016 For a clean held transition, latency from the first in_raw-sampling edge to the level_out change SHALL be exactly 2 + DEBOUNCE_CYCLES cycles.
REQ-017 rise_pulse / fall_pulse SHALL be registered, high for exactly the first cycle level_out shows its new value, and never both high.
REQ-018 capture_out SHALL set on the EDGE_MODE-selected accepted edge, in the same cycle as the corresponding pulse.
REQ-019 clear SHALL drive capture_out low on the next cycle.
REQ-020 clear coincident with a set event SHALL leave capture_out at 1 (no event lost).
REQ-021 With DEBOUNCE_CYCLES = 1, level_out SHALL follow s2 with one cycle of delay.
REQ-022 A glitch shorter than DEBOUNCE_CYCLES synchronised cycles SHALL produce no change on any output.

Reset
REQ-023 While reset_n = 0: synchroniser flops and level_out = RESET_LEVEL, counter = 0, rise_pulse = fall_pulse = capture_out = 0.
REQ-024 Reset asserted mid-count SHALL abort the count; no pulse or capture SHALL be generated from it after release.
REQ-025 After reset release, no edge SHALL be reported unless in_raw differs from RESET_LEVEL for the full debounce period.

Structure
REQ-026 EDGE_MODE encodings (EDGE_RISE = 0, EDGE_FALL = 1, EDGE_BOTH = 2) SHALL live in shared package nios_tester_pkg.
REQ-027 The two-flop synchroniser SHALL be sub-module nios_tester_sync2 (parameterised reset value), reusable by other tester inputs.
REQ-028 No combinational path from in_raw or clear to any output.

Verification (DEBOUNCE_CYCLES = 4, RESET_LEVEL = 1, EDGE_MODE = 2 unless stated)
REQ-029 Reset with in_raw = 1 -> level_out = 1, capture_out = 0, both pulses 0; hold 20 cycles -> no change.
REQ-030 in_raw 1->0 held -> level_out falls exactly 6 cycles later, fall_pulse high 1 cycle, capture_out = 1 from the same cycle.
REQ-031 in_raw low for 3 cycles, then high -> level_out stays 1, no pulse, capture_out stays 0.
REQ-032 Bounce 0,1,0,1,0 (2 cycles each), then hold 0 -> single fall_pulse exactly 6 cycles after the last transition.
REQ-033 clear pulse -> capture_out = 0 next cycle; clear in the same cycle as a rise_pulse -> capture_out stays 1; EDGE_MODE = 0 run: a fall sets nothing.
REQ-034 reset_n pulsed low after 3 counting cycles -> outputs return to reset values immediately; release with in_raw = 0 -> fall_pulse 6 cycles after release.
